// File: rtl/register_pkg.sv
// Constants shared by the register data path: default word width and the
// serializer state encoding.
package register_pkg;

  localparam int REG_WIDTH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/register_serializer.sv
// Parallel-in, serial-out transmitter: loads a WIDTH-bit word and shifts it
// out one bit per shift_en cycle, with valid/frame-start/done markers.
module register_serializer
  import register_pkg::*;
#(
  parameter int WIDTH     = REG_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  output logic             ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             fs_q, fs_d;
  logic [WIDTH-1:0] load_word;

  // The shift register always holds the bit on the wire at its top position,
  // so LSB-first words are bit-reversed on capture.
  always_comb begin
    load_word = '0;
    for (int i = 0; i < WIDTH; i++)
      load_word[i] = MSB_FIRST ? data_in[i] : data_in[WIDTH-1-i];
  end

  assign done  = (state_q == ST_SHIFT) && (count_q == LAST) && shift_en;
  assign ready = (state_q == ST_IDLE) || done;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    sout_d  = sout_q;
    valid_d = valid_q;
    fs_d    = fs_q;
    if (ready && load) begin
      state_d = ST_SHIFT;
      shreg_d = load_word;
      count_d = '0;
      sout_d  = load_word[WIDTH-1];
      valid_d = 1'b1;
      fs_d    = 1'b1;
    end else if (state_q == ST_SHIFT && shift_en) begin
      if (done) begin
        state_d = ST_IDLE;
        shreg_d = '0;
        count_d = '0;
        sout_d  = 1'b0;
        valid_d = 1'b0;
        fs_d    = 1'b0;
      end else begin
        shreg_d = shreg_q << 1;
        count_d = count_q + 1'b1;
        sout_d  = shreg_q[WIDTH-2];
        fs_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      count_q <= '0;
      sout_q  <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
    end
  end

  assign serial_out   = sout_q;
  assign serial_valid = valid_q;
  assign frame_start  = fs_q;

endmodule

// File: tb/tb_register_serializer.sv
// Bench for register_serializer: an MSB-first and an LSB-first instance share
// stimulus; a word-level model is checked every cycle, plus literal streams.
module tb_register_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic         shift_en = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [1:0]   ready, sout, valid, fs, done;

  register_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .shift_en(shift_en),
    .ready(ready[0]), .serial_out(sout[0]), .serial_valid(valid[0]),
    .frame_start(fs[0]), .done(done[0]));

  register_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .shift_en(shift_en),
    .ready(ready[1]), .serial_out(sout[1]), .serial_valid(valid[1]),
    .frame_start(fs[1]), .done(done[1]));

  always #5 clk = ~clk;

  // Model: seq[i][k] is the k-th bit on the wire, left[i] counts bits still
  // to be consumed including the one presented (0 = idle).
  logic [W-1:0] seq [2];
  int           left [2];
  bit           first [2];
  bit           m_ed, m_er;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        left[i]  = 0;
        first[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_ed = (left[i] == 1) && (shift_en === 1'b1);
        m_er = (left[i] == 0) || m_ed;
        if (m_er && load === 1'b1) begin
          for (int k = 0; k < W; k++)
            seq[i][k] = (i == 0) ? data_in[W-1-k] : data_in[k];
          left[i]  = W;
          first[i] = 1'b1;
        end else if (left[i] > 0 && shift_en === 1'b1) begin
          left[i]  = left[i] - 1;
          first[i] = 1'b0;
        end
      end
    end
  end

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] cap_m = '0, cap_l = '0;
  int          nd = 0, nf = 0, nv = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    for (int i = 0; i < 2; i++) begin
      logic eo, ed, er;
      eo = (left[i] > 0) ? seq[i][W-left[i]] : 1'b0;
      ed = (left[i] == 1) && shift_en;
      er = (left[i] == 0) || ed;
      check($sformatf("serial_out[%0d]", i), 64'(sout[i]), 64'(eo));
      check($sformatf("serial_valid[%0d]", i), 64'(valid[i]), 64'(left[i] > 0));
      check($sformatf("frame_start[%0d]", i), 64'(fs[i]), 64'(first[i]));
      check($sformatf("done[%0d]", i), 64'(done[i]), 64'(ed));
      check($sformatf("ready[%0d]", i), 64'(ready[i]), 64'(er));
    end
    if (valid[0] && shift_en) begin
      cap_m = {cap_m[62:0], sout[0]};
      if (fs[0]) nf++;
    end
    if (valid[1] && shift_en) cap_l = {cap_l[62:0], sout[1]};
    if (done[0]) nd++;
    if (valid[0]) nv++;
  endtask

  // Each step checks at the falling edge, then returns 1 after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_cycle();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [W-1:0] d);
    load = 1'b1;
    data_in = d;
    step(1);
    load = 1'b0;
    data_in = 'x;
  endtask

  int nd0, nf0, nv0;

  initial begin
    #1;
    check("rst serial_out", 64'(sout), 64'(2'b00));
    check("rst serial_valid", 64'(valid), 64'(2'b00));
    check("rst frame_start", 64'(fs), 64'(2'b00));
    check("rst ready", 64'(ready), 64'(2'b11));
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);

    // Single word, continuous enable
    shift_en = 1'b1;
    nd0 = nd; nf0 = nf;
    start(8'h55);
    step(9);
    check("t1 msb stream", cap_m[7:0], 64'(8'h55));
    check("t1 lsb stream", cap_l[7:0], 64'(8'hAA));
    check("t1 done count", 64'(nd - nd0), 64'(1));
    check("t1 frame count", 64'(nf - nf0), 64'(1));

    start(8'hA5);
    step(9);
    check("t2 lsb stream", cap_l[7:0], 64'(8'hA5));
    check("t2 msb stream", cap_m[7:0], 64'(8'hA5));

    // Back-to-back reload in the done cycle
    nd0 = nd; nf0 = nf;
    start(8'hAA);
    step(7);
    load = 1'b1;
    data_in = 8'hFF;
    step(1);
    load = 1'b0;
    data_in = 'x;
    step(9);
    check("t3 msb stream", cap_m[15:0], 64'(16'hAAFF));
    check("t3 lsb stream", cap_l[15:0], 64'(16'h55FF));
    check("t3 done count", 64'(nd - nd0), 64'(2));
    check("t3 frame count", 64'(nf - nf0), 64'(2));

    // Stall for three cycles while bit 3 (a zero) is presented
    nv0 = nv;
    start(8'hC3);
    step(2);
    shift_en = 1'b0;
    step(1);
    check("t4 held bit", 64'(sout[0]), 64'(1'b0));
    check("t4 held valid", 64'(valid[0]), 64'(1'b1));
    step(2);
    shift_en = 1'b1;
    step(7);
    check("t4 msb stream", cap_m[7:0], 64'(8'hC3));
    check("t4 lsb stream", cap_l[7:0], 64'(8'hC3));
    check("t4 valid cycles", 64'(nv - nv0), 64'(11));

    // Load pulse while busy is ignored
    nd0 = nd; nf0 = nf;
    start(8'h0F);
    step(2);
    load = 1'b1;
    data_in = 8'hF0;
    step(1);
    load = 1'b0;
    data_in = 'x;
    step(6);
    check("t5 msb stream", cap_m[7:0], 64'(8'h0F));
    check("t5 lsb stream", cap_l[7:0], 64'(8'hF0));
    check("t5 frame count", 64'(nf - nf0), 64'(1));
    check("t5 done count", 64'(nd - nd0), 64'(1));
    check("t5 idle valid", 64'(valid), 64'(2'b00));

    // Asynchronous reset mid-word
    nd0 = nd;
    start(8'hFF);
    step(3);
    #2;
    rst = 1'b1;
    #1;
    check("t6 rst serial_out", 64'(sout), 64'(2'b00));
    check("t6 rst valid", 64'(valid), 64'(2'b00));
    check("t6 rst ready", 64'(ready), 64'(2'b11));
    check("t6 rst done", 64'(done), 64'(2'b00));
    step(2);
    rst = 1'b0;
    step(1);
    check("t6 no done pulse", 64'(nd - nd0), 64'(0));
    start(8'h81);
    step(9);
    check("t6 msb stream", cap_m[7:0], 64'(8'h81));
    check("t6 lsb stream", cap_l[7:0], 64'(8'h81));
    check("t6 done count", 64'(nd - nd0), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
